// File: rtl/stream_accu_pkg.sv
// stream_accu_pkg: shared width helpers for stream_accu and its instantiating parents.
// Latency: n/a (constant functions only).
// Backpressure: n/a.
package stream_accu_pkg;

  // Output width of a group sum: REP beats of DATA_WIDTH bits cannot exceed
  // DATA_WIDTH + clog2(REP) bits. REP=1 collapses to DATA_WIDTH.
  function automatic int out_width(input int data_width, input int rep);
    return data_width + $clog2(rep);
  endfunction

  // Beat counter width; at least one bit so REP=1 still has a legal vector.
  function automatic int cnt_width(input int rep);
    return (rep > 1) ? $clog2(rep) : 1;
  endfunction

endpackage

// File: rtl/stream_accu.sv
// stream_accu: sums every REP consecutive unsigned input beats into one output word.
// Latency: 1 cycle from the group-closing beat to ovld.
// Backpressure: non-closing beats always accepted; a closing beat waits only while an
//   undelivered output is held (irdy = !ovld || ordy), so drain+close runs bubble-free.
//
// Ports:
//   clk, rst            rising-edge clock, synchronous active-high reset
//   idat/ivld/irdy      input beat stream (DATA_WIDTH bits, unsigned)
//   ilast               early group end (only with STREAM_ACCU_LAST_EN defined)
//   odat/ovld/ordy      group-sum stream (OUT_WIDTH bits)
//
// Optional feature: define STREAM_ACCU_LAST_EN to add ilast; an accepted beat with
// ilast=1 closes the group at any count. Default build: groups are exactly REP beats.
module stream_accu
  import stream_accu_pkg::*;
#(
  parameter  int DATA_WIDTH = 9,
  parameter  int REP        = 7,
  localparam int OUT_WIDTH  = out_width(DATA_WIDTH, REP)
) (
  input  logic                  clk,
  input  logic                  rst,
`ifdef STREAM_ACCU_LAST_EN
  input  logic                  ilast,
`endif
  input  logic [DATA_WIDTH-1:0] idat,
  input  logic                  ivld,
  output logic                  irdy,
  output logic [OUT_WIDTH-1:0]  odat,
  output logic                  ovld,
  input  logic                  ordy
);

  localparam int CNT_WIDTH = cnt_width(REP);

  logic [CNT_WIDTH-1:0] r_cnt;
  logic [OUT_WIDTH-1:0] r_acc;
  logic [OUT_WIDTH-1:0] r_odat;
  logic                 r_ovld;

  logic                 w_close;
  logic                 w_accept;
  logic [OUT_WIDTH-1:0] w_idat_ext;
  logic [OUT_WIDTH-1:0] w_sum;

  // The beat now on the input closes its group if it is the REP-th beat
  // (or flagged as last when the early-termination feature is built in).
`ifdef STREAM_ACCU_LAST_EN
  assign w_close = (r_cnt == CNT_WIDTH'(REP - 1)) || ilast;
`else
  assign w_close = (r_cnt == CNT_WIDTH'(REP - 1));
`endif

  // Only the closing beat needs the output register free; the drain and the
  // new write may happen on the same edge. Deliberately independent of ivld.
  assign irdy     = !rst && (!w_close || !r_ovld || ordy);
  assign w_accept = ivld && irdy;

  assign w_idat_ext = OUT_WIDTH'(idat);
  // First beat of a group loads instead of adding, so the accumulator never
  // needs clearing between groups.
  assign w_sum = (r_cnt == '0) ? w_idat_ext : (r_acc + w_idat_ext);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt  <= '0;
      r_acc  <= '0;
      r_odat <= '0;
      r_ovld <= 1'b0;
    end else begin
      if (r_ovld && ordy) begin
        r_ovld <= 1'b0;
      end
      if (w_accept) begin
        if (w_close) begin
          // Set after the drain above so a simultaneous drain+close keeps ovld high.
          r_odat <= w_sum;
          r_ovld <= 1'b1;
          r_cnt  <= '0;
          r_acc  <= '0;
        end else begin
          r_acc  <= w_sum;
          r_cnt  <= r_cnt + CNT_WIDTH'(1);
        end
      end
    end
  end

  assign odat = r_odat;
  assign ovld = r_ovld;

endmodule

// File: tb/tb_stream_accu.sv
module tb_stream_accu;

  localparam int DW  = 9;
  localparam int REP = 7;
  localparam int OW  = 12;
  localparam int SEND_BOUND = 200;

  logic          clk  = 1'b0;
  logic          rst  = 1'b1;
  logic [DW-1:0] idat = '0;
  logic          ivld = 1'b0;
  logic          irdy;
  logic [OW-1:0] odat;
  logic          ovld;
  logic          ordy = 1'b0;
`ifdef STREAM_ACCU_LAST_EN
  logic          ilast = 1'b0;
`endif

  int checks = 0;
  int errors = 0;
  int exp_q[$];
  int part[$];
  int pops = 0;
  int ordy_mode = 0;  // 0: always ready, 1: random 1-in-7 idle, 2: held low

  stream_accu #(.DATA_WIDTH(DW), .REP(REP)) dut (
    .clk  (clk),
    .rst  (rst),
`ifdef STREAM_ACCU_LAST_EN
    .ilast(ilast),
`endif
    .idat (idat),
    .ivld (ivld),
    .irdy (irdy),
    .odat (odat),
    .ovld (ovld),
    .ordy (ordy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Reference model: a group is a list of accepted beats; it closes at REP
  // beats or on a last flag, and its expected output is the plain sum.
  task automatic model_accept(input int d, input bit last);
    int s;
    part.push_back(d);
    if (last || part.size() == REP) begin
      s = 0;
      foreach (part[i]) s += part[i];
      exp_q.push_back(s);
      part.delete();
    end
  endtask

  task automatic send_beat(input int d, input bit last, output int waited);
    bit acc;
    waited = 0;
    ivld = 1'b1;
    idat = DW'(d);
`ifdef STREAM_ACCU_LAST_EN
    ilast = last;
`endif
    forever begin
      @(negedge clk);
      acc = irdy;
      @(posedge clk);
      if (acc) begin
        model_accept(d & ((1 << DW) - 1), last);
        break;
      end
      waited++;
      if (waited > SEND_BOUND) begin
        chk("send_timeout", waited, 0);
        break;
      end
    end
    #1;
    ivld = 1'b0;
`ifdef STREAM_ACCU_LAST_EN
    ilast = 1'b0;
`endif
  endtask

  // One-cycle synchronous reset; pending model state is discarded with it.
  task automatic do_reset();
    @(posedge clk);
    #1;
    rst  = 1'b1;
    ivld = 1'b0;
    exp_q.delete();
    part.delete();
    @(posedge clk);
    #1;
    chk("rst_ovld", ovld, 0);
    chk("rst_odat", odat, 0);
    chk("rst_irdy", irdy, 0);
    rst = 1'b0;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 4000) begin
      @(posedge clk);
      n++;
    end
    chk("drain_timeout", exp_q.size(), 0);
    @(posedge clk);
    #1;
  endtask

  // ordy driver
  initial begin
    forever begin
      @(posedge clk);
      #1;
      case (ordy_mode)
        0:       ordy = 1'b1;
        2:       ordy = 1'b0;
        default: ordy = ($urandom_range(0, 6) != 0);
      endcase
    end
  end

  // Monitor: pops the scoreboard on each output transfer and checks that a
  // stalled output does not change.
  initial begin
    bit          prev_hold;
    logic [OW-1:0] prev_dat;
    prev_hold = 1'b0;
    prev_dat  = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_hold = 1'b0;
      end else begin
        if (prev_hold) begin
          chk("hold_ovld", ovld, 1);
          chk("hold_odat", odat, prev_dat);
        end
        if (ovld && ordy) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_output", odat, -1);
          end else begin
            chk("odat", odat, exp_q.pop_front());
          end
          pops++;
        end
        prev_hold = ovld && !ordy;
        prev_dat  = odat;
      end
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int w, wsum, p0;
    bit blocked;
    int v;

    do_reset();

    // Beats 0..6, ordy=1: 21 visible one cycle after the closing beat.
    ordy_mode = 0;
    wsum = 0;
    for (int i = 0; i < 6; i++) begin
      send_beat(i, 1'b0, w);
      wsum += w;
    end
    chk("no_early_ovld", ovld, 0);
    send_beat(6, 1'b0, w);
    wsum += w;
    chk("lat_ovld", ovld, 1);
    chk("lat_odat", odat, 21);
    chk("full_rate", wsum, 0);
    wait_drain();

    // Maximum input value: 7 * 511 = 3577.
    for (int i = 0; i < REP; i++) send_beat(511, 1'b0, w);
    wait_drain();

    // Output stalled for 20 cycles while two groups of 1s arrive.
    ordy_mode = 2;
    @(posedge clk);
    #1;
    wsum = 0;
    for (int i = 0; i < 2 * REP - 1; i++) begin
      send_beat(1, 1'b0, w);
      wsum += w;
    end
    chk("stall_noncl_rdy", wsum, 0);
    chk("stall_vld", ovld, 1);
    chk("stall_dat", odat, 7);
    ivld = 1'b1;
    idat = DW'(1);
    blocked = 1'b1;
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      if (irdy) blocked = 1'b0;
      @(posedge clk);
      #1;
    end
    chk("close_blocked", blocked, 1);
    p0 = pops;
    ordy_mode = 0;
    send_beat(1, 1'b0, w);
    wait_drain();
    chk("stall_pops", pops - p0, 2);

    // Reset mid-group discards the partial sum.
    p0 = pops;
    for (int i = 0; i < 3; i++) send_beat(9, 1'b0, w);
    do_reset();
    for (int i = 0; i < REP; i++) send_beat(1, 1'b0, w);
    wait_drain();
    chk("rst_mid_pops", pops - p0, 1);

`ifdef STREAM_ACCU_LAST_EN
    p0 = pops;
    send_beat(5, 1'b0, w);
    send_beat(5, 1'b0, w);
    send_beat(5, 1'b1, w);
    for (int i = 1; i <= 7; i++) send_beat(i, 1'b0, w);
    wait_drain();
    chk("last_pops", pops - p0, 2);
`endif

    // Random idle on both sides over 1357 groups of consecutive integers.
    ordy_mode = 1;
    p0 = pops;
    v = 0;
    for (int g = 0; g < 1357; g++) begin
      for (int b = 0; b < REP; b++) begin
        if ($urandom_range(0, 10) == 0) begin
          @(posedge clk);
          #1;
        end
        send_beat(v, 1'b0, w);
        v++;
      end
    end
    ordy_mode = 0;
    wait_drain();
    chk("rand_pops", pops - p0, 1357);
    chk("final_queue", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/stream_accu.md
STREAM_ACCU -- requirements
Module: stream_accu

Interface
REQ-001 The block SHALL have one clock and one reset: reset is synchronous and active-high, with ports named clk and rst.
REQ-002 Parameter DATA_WIDTH, default 9: width of one unsigned input beat; legal range 1..32.
REQ-003 Parameter REP, default 7: number of consecutive input beats summed per output; legal range 1..256.
REQ-004 Derived width OUT_WIDTH SHALL equal DATA_WIDTH+$clog2(REP) (DATA_WIDTH when REP=1).
REQ-005 clk  input  1  rising-edge clock.
REQ-006 rst  input  1  synchronous active-high reset.
REQ-007 idat  input  DATA_WIDTH  input beat, unsigned.
REQ-008 ivld / irdy  input / output  1 / 1  input valid and ready.
REQ-009 odat  output  OUT_WIDTH  group sum.
REQ-010 ovld / ordy  output / input  1 / 1  output valid and ready.
REQ-011 ilast  input  1  early group end; present only with STREAM_ACCU_LAST_EN.

Function
REQ-012 A beat SHALL transfer on a rising edge where ivld&&irdy; an output SHALL transfer where ovld&&ordy.
REQ-013 Beat counter cnt SHALL run 0..REP-1, increment per accepted beat, and wrap to 0 after the group-closing beat.
REQ-014 Accumulator SHALL load idat on the first beat of a group (cnt==0) and add idat otherwise, unsigned, at OUT_WIDTH bits, without overflow by construction.
REQ-015 The group-closing beat SHALL write acc+idat (or idat when REP=1) to the output register, and ovld SHALL rise the following cycle: latency is 1 cycle from closing beat to ovld.
REQ-016 odat/ovld SHALL hold stable while ovld&&!ordy.
REQ-017 irdy SHALL be 1 for every non-closing beat regardless of output state.
REQ-018 For a closing beat, irdy SHALL equal !ovld||ordy, so that simultaneous drain and close yields back-to-back outputs with no bubble.
REQ-019 irdy SHALL NOT depend on ivld.
REQ-020 ovld SHALL NOT depend combinationally on ordy.
REQ-021 Sustained throughput SHALL be one input beat per cycle when ordy is held at 1.

Reset
REQ-022 On rst SHALL set: ovld=0, cnt=0, accumulator=0, odat=0.
REQ-023 irdy SHALL be 0 while rst is 1.
REQ-024 Reset mid-group SHALL discard the partial sum and any undelivered output; the first beat after reset SHALL start a new group.

Configuration
REQ-025 Macro STREAM_ACCU_LAST_EN SHALL control the early-termination feature.
REQ-026 With STREAM_ACCU_LAST_EN defined: port ilast SHALL exist, and an accepted beat with ilast=1 SHALL be treated as group-closing at any cnt, following REQ-015/REQ-018 and resetting cnt to 0.
REQ-027 Without STREAM_ACCU_LAST_EN: no ilast port, and groups SHALL always be exactly REP beats.

Structure
REQ-028 A shared package stream_accu_pkg SHALL hold the function computing OUT_WIDTH from DATA_WIDTH and REP, for use by instantiating parents.
REQ-029 The block SHALL be implemented as a single module with no sub-module, since the output register is too small to warrant one.
REQ-030 The block is intended to consume the repeated tap stream of the adjacent tap stage, with REP matched to that stage's tap repetition count.

Verification (DATA_WIDTH=9, REP=7)
REQ-031 Beats 0..6 with ordy=1 SHALL produce odat=21 one cycle after beat 6.
REQ-032 Seven beats of 511 SHALL produce odat=3577 (OUT_WIDTH=12).
REQ-033 With ordy=0 for 20 cycles while two groups of 1s are fed: first output 7 held stable; irdy=0 only on the second group's 7th beat; after ordy=1, outputs SHALL be 7, 7.
REQ-034 Three beats of 9 followed by 1-cycle rst, then seven beats of 1, SHALL produce exactly one output, 7.
REQ-035 Randomised ivld/ordy (1/11 and 1/7 idle) over 1357 groups of consecutive integers SHALL match a reference sum per group, with no loss or duplication.
REQ-036 With STREAM_ACCU_LAST_EN: beats 5, 5, 5(ilast=1), then 1..7, SHALL produce 15 then 28.
